// File: rtl/pixel_pack_pkg.sv
// Shared types and sizing helpers for the pixel packing writer.
// PIXEL_PACK_BSWAP_EN selects MS-lane-first packing in lane_mask.
package pixel_pack_pkg;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  // Widest BRAM word (in bytes) the mask helper can describe.
  localparam int MAX_WORD_B = 128;

  function automatic int calc_ppw(input int data_w, input int pix_w);
    return data_w / pix_w;
  endfunction

  function automatic int calc_word_b(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int calc_region_b(input int data_w, input int pix_w, input int img_pixels);
    int ppw;
    ppw = data_w / pix_w;
    return ((img_pixels + ppw - 1) / ppw) * (data_w / 8);
  endfunction

  // Byte enables covering the first count lanes of a word of word_b bytes.
  function automatic logic [MAX_WORD_B-1:0] lane_mask(input int count, input int lane_b,
                                                      input int word_b);
    logic [MAX_WORD_B-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WORD_B; i++) begin
`ifdef PIXEL_PACK_BSWAP_EN
      if (i < word_b && i >= word_b - count * lane_b) m[i] = 1'b1;
`else
      if (i < word_b && i < count * lane_b) m[i] = 1'b1;
`endif
    end
    return m;
  endfunction

endpackage

// File: rtl/pixel_pack_writer_lane_reg.sv
// Lane packing register: merges pixels into the current word and tracks the lane.
// PIXEL_PACK_BSWAP_EN places the first pixel of a word in the MS lane.
module pack_lane_reg
  import pixel_pack_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [PIX_W-1:0]  pixel,
  output logic [DATA_W-1:0] word_next,
  output logic [DATA_W-1:0] word_cur,
  output logic              lane_last,
  output logic [DATA_W/8-1:0] part_mask
);

  localparam int PPW    = calc_ppw(DATA_W, PIX_W);
  localparam int WORD_B = calc_word_b(DATA_W);
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

  logic [LANE_W-1:0]     lane_q;
  logic [DATA_W-1:0]     word_q;
  logic [MAX_WORD_B-1:0] mask_full;
  int                    slot;

  always_comb begin
`ifdef PIXEL_PACK_BSWAP_EN
    slot = PPW - 1 - int'(lane_q);
`else
    slot = int'(lane_q);
`endif
    word_next = word_q;
    for (int n = 0; n < PPW; n++) begin
      if (n == slot) word_next[n*PIX_W +: PIX_W] = pixel;
    end
  end

  assign word_cur  = word_q;
  assign lane_last = (lane_q == LANE_W'(PPW - 1));
  // After the last accept, lane_q equals the number of occupied lanes.
  assign mask_full = lane_mask(int'(lane_q), PIX_W / 8, WORD_B);
  assign part_mask = mask_full[WORD_B-1:0];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (accept) begin
      if (lane_last) begin
        lane_q <= '0;
        word_q <= '0;
      end else begin
        lane_q <= lane_q + LANE_W'(1);
        word_q <= word_next;
      end
    end
  end

endmodule

// File: rtl/pixel_pack_writer.sv
// Packs a pixel stream into BRAM words, ping-ponging between NUM_BUF regions.
// Lane order follows PIXEL_PACK_BSWAP_EN (see pack_lane_reg).
//
// state | meaning
// IDLE  | waiting for start; pointer tracks the selected region base
// PACK  | accepting pixels, one full-word write per PPW pixels
// FLUSH | writes the trailing partial word with masked enables
// DONE  | final write on the bus; pulses image_done, advances buf_sel
module pixel_pack_writer
  import pixel_pack_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                PIX_W      = 8,
  parameter int                IMG_PIXELS = 1024,
  parameter int                NUM_BUF    = 2,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] OUT_BASE   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PIX_W-1:0]    pixel_i,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_data,
  output logic [DATA_W/8-1:0] write_enable,
  output logic [((NUM_BUF > 1) ? $clog2(NUM_BUF) : 1)-1:0] buf_sel,
  output logic                image_done,
  output logic                busy,
  output logic                overflow_err
);

  localparam int WORD_B   = calc_word_b(DATA_W);
  localparam int REGION_B = calc_region_b(DATA_W, PIX_W, IMG_PIXELS);
  localparam int BUF_W    = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int CNT_W    = $clog2(IMG_PIXELS + 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d, region_base;
  logic [CNT_W-1:0]    left_q, left_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d, word_next, word_cur;
  logic [WORD_B-1:0]   we_d, part_mask;
  logic [BUF_W-1:0]    buf_d;
  logic                done_d, busy_d, ovf_d, accept, lane_clear, lane_last;

  assign pixel_ready = (state_q == PACK);
  assign accept      = pixel_valid && pixel_ready;
  assign lane_clear  = (state_q == IDLE);
  assign region_base = OUT_BASE + ADDR_W'(buf_sel) * ADDR_W'(REGION_B);

  pack_lane_reg #(.DATA_W(DATA_W), .PIX_W(PIX_W)) u_lane (
    .clk       (clk),
    .reset     (reset),
    .clear     (lane_clear),
    .accept    (accept),
    .pixel     (pixel_i),
    .word_next (word_next),
    .word_cur  (word_cur),
    .lane_last (lane_last),
    .part_mask (part_mask)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    addr_d  = bram_addr;
    data_d  = bram_data;
    we_d    = '0;
    buf_d   = buf_sel;
    done_d  = 1'b0;
    busy_d  = busy;
    ovf_d   = overflow_err;
    case (state_q)
      IDLE: begin
        ptr_d  = region_base;
        left_d = CNT_W'(IMG_PIXELS);
        // The image_done cycle is still part of the finishing image.
        if (start && !image_done) begin
          state_d = PACK;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      PACK: begin
        if (accept) begin
          left_d = left_q - CNT_W'(1);
          if (lane_last) begin
            addr_d = ptr_q;
            data_d = word_next;
            we_d   = '1;
            ptr_d  = ptr_q + ADDR_W'(WORD_B);
          end
          if (left_q == CNT_W'(1)) state_d = lane_last ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        addr_d  = ptr_q;
        data_d  = word_cur;
        we_d    = part_mask;
        ptr_d   = ptr_q + ADDR_W'(WORD_B);
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        buf_d   = (buf_sel == BUF_W'(NUM_BUF - 1)) ? '0 : buf_sel + BUF_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pixel_valid && !pixel_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      left_q       <= '0;
      bram_addr    <= '0;
      bram_data    <= '0;
      write_enable <= '0;
      buf_sel      <= '0;
      image_done   <= 1'b0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      bram_addr    <= addr_d;
      bram_data    <= data_d;
      write_enable <= we_d;
      buf_sel      <= buf_d;
      image_done   <= done_d;
      busy         <= busy_d;
      overflow_err <= ovf_d;
    end
  end

endmodule
